// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - arbitrates core load/store and debug/loader access to the single-port data memory
module dmem_arbiter #(
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_ADDR_WIDTH   = 8,
  parameter int P_STARVE_LIMIT = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_core_req,
  input  logic                                  i_core_we,
  input  logic [P_ADDR_WIDTH-1:0]               i_core_addr,
  input  logic [P_DATA_WIDTH-1:0]               i_core_wdata,
  output logic                                  o_core_gnt,
  output logic                                  o_core_rvalid,
  output logic [P_DATA_WIDTH-1:0]               o_core_rdata,
  input  logic                                  i_dbg_req,
  input  logic                                  i_dbg_we,
  input  logic [P_ADDR_WIDTH-1:0]               i_dbg_addr,
  input  logic [P_DATA_WIDTH-1:0]               i_dbg_wdata,
  input  logic                                  i_dbg_lock,
  output logic                                  o_dbg_gnt,
  output logic                                  o_dbg_rvalid,
  output logic [P_DATA_WIDTH-1:0]               o_dbg_rdata,
  output logic                                  o_mem_en,
  output logic                                  o_mem_we,
  output logic [P_ADDR_WIDTH-1:0]               o_mem_addr,
  output logic [P_DATA_WIDTH-1:0]               o_mem_wdata,
  input  logic [P_DATA_WIDTH-1:0]               i_mem_rdata,
  output logic [$clog2(P_STARVE_LIMIT+1)-1:0]   o_starve_cnt
);

  localparam int SW = $clog2(P_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(P_STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  owner_t        resp_owner;
  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic          core_gnt;
  logic          dbg_gnt;

  assign starved = (starve_cnt == LIMIT);

  // Grants are suppressed while reset is held so the memory sees no access.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!i_rst) begin
      if (i_dbg_lock) begin
        dbg_gnt = i_dbg_req;
      end else if (starved && i_dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (i_core_req) begin
        core_gnt = 1'b1;
      end else begin
        dbg_gnt = i_dbg_req;
      end
    end
  end

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (core_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_core_we;
      o_mem_addr  = i_core_addr;
      o_mem_wdata = i_core_wdata;
    end else if (dbg_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_dbg_we;
      o_mem_addr  = i_dbg_addr;
      o_mem_wdata = i_dbg_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
      resp_owner <= OWN_NONE;
    end else begin
      if (i_dbg_req && !dbg_gnt) begin
        if (!starved) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end

      // Only reads expect data back; writes leave the response slot empty.
      if (core_gnt && !i_core_we) begin
        resp_owner <= OWN_CORE;
      end else if (dbg_gnt && !i_dbg_we) begin
        resp_owner <= OWN_DBG;
      end else begin
        resp_owner <= OWN_NONE;
      end
    end
  end

  assign o_core_gnt    = core_gnt;
  assign o_dbg_gnt     = dbg_gnt;
  assign o_core_rvalid = (resp_owner == OWN_CORE);
  assign o_dbg_rvalid  = (resp_owner == OWN_DBG);
  assign o_core_rdata  = (resp_owner == OWN_CORE) ? i_mem_rdata : '0;
  assign o_dbg_rdata   = (resp_owner == OWN_DBG) ? i_mem_rdata : '0;
  assign o_starve_cnt  = starve_cnt;

endmodule
